// File: rtl/mdu_pipe_ctrl.sv
// rtl/mdu_pipe_ctrl.sv - HI/LO multiply/divide sequencer for the EXE stage
//
// Launches the external pipelined multiplier or the iterative divider for the
// MDU op held in the EXE pipeline register. It holds the front of the pipeline
// with MDU_Busy until the result is available, then writes HI/LO exactly once.
// An EXE flush aborts the operation and drains the unit.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   EXE_MDUOp         0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
//   EXE_Flush         EXE stage is being flushed this cycle
//   Ext_Stall         pipeline held by another source
//   EXE_BusA/B        rs/rt operands; these are routed straight to the units
//   Mul_Start/Signed  multiplier launch pulse and signedness
//   Mul_Result        product, valid MUL_LAT cycles after Mul_Start
//   Div_Start/Signed  divider launch pulse and signedness
//   Div_Abort         divider cancel pulse
//   Div_Done/Quot/Rem divider completion pulse and results
//   MDU_Busy          stall request to IF/ID/EXE
//   HI_Wr/LO_Wr       HI/LO write enables
//   HI_Data/LO_Data   HI/LO write data

module mdu_pipe_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EXE_MDUOp,
    input  logic        EXE_Flush,
    input  logic        Ext_Stall,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    output logic        Mul_Start,
    output logic        Mul_Signed,
    input  logic [63:0] Mul_Result,
    output logic        Div_Start,
    output logic        Div_Signed,
    output logic        Div_Abort,
    input  logic        Div_Done,
    input  logic [31:0] Div_Quot,
    input  logic [31:0] Div_Rem,
    output logic        MDU_Busy,
    output logic        HI_Wr,
    output logic        LO_Wr,
    output logic [31:0] HI_Data,
    output logic [31:0] LO_Data
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_WAIT = 3'd2,
        S_DONE     = 3'd3,
        S_DRAIN    = 3'd4
    } state_t;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;
    logic        written, written_nxt;

    logic op_mul, op_div, op_mthi, op_mtlo;
    logic launch_req, div_zero;

    assign op_mul     = (EXE_MDUOp == 3'd1) || (EXE_MDUOp == 3'd2);
    assign op_div     = (EXE_MDUOp == 3'd3) || (EXE_MDUOp == 3'd4);
    assign op_mthi    = (EXE_MDUOp == 3'd5);
    assign op_mtlo    = (EXE_MDUOp == 3'd6);
    assign launch_req = (op_mul || op_div) && !EXE_Flush;
    assign div_zero   = (EXE_BusB == 32'd0);

    assign Mul_Signed = (EXE_MDUOp == 3'd1);
    assign Div_Signed = (EXE_MDUOp == 3'd3);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            written <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            written <= written_nxt;
        end
    end

    // Next-state logic; a flush overrides every other decision.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        written_nxt = written;
        case (state)
            S_IDLE: begin
                if (launch_req && op_mul) begin
                    state_nxt = S_MUL_WAIT;
                    cnt_nxt   = 4'd1;
                end else if (launch_req && op_div && !div_zero) begin
                    state_nxt = S_DIV_WAIT;
                end
            end
            S_MUL_WAIT: begin
                if (EXE_Flush) begin
                    // The product still emerges from the multiplier but is never latched.
                    state_nxt = S_DRAIN;
                    cnt_nxt   = 4'd0;
                end else if (cnt == MUL_LAT_C) begin
                    hi_nxt    = Mul_Result[63:32];
                    lo_nxt    = Mul_Result[31:0];
                    cnt_nxt   = 4'd0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_DIV_WAIT: begin
                if (EXE_Flush) begin
                    state_nxt = S_DRAIN;
                end else if (Div_Done) begin
                    hi_nxt    = Div_Rem;
                    lo_nxt    = Div_Quot;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (EXE_Flush || !Ext_Stall) begin
                    state_nxt   = S_IDLE;
                    written_nxt = 1'b0;
                end else begin
                    // Held by another stall source: remember the write already happened.
                    written_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic; everything is forced quiet while reset is asserted.
    always_comb begin
        Mul_Start = 1'b0;
        Div_Start = 1'b0;
        Div_Abort = 1'b0;
        MDU_Busy  = 1'b0;
        HI_Wr     = 1'b0;
        LO_Wr     = 1'b0;
        HI_Data   = hi_q;
        LO_Data   = lo_q;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (launch_req && op_mul) begin
                        Mul_Start = 1'b1;
                        MDU_Busy  = 1'b1;
                    end else if (launch_req && op_div && !div_zero) begin
                        Div_Start = 1'b1;
                        MDU_Busy  = 1'b1;
                    end else if (!EXE_Flush && op_mthi) begin
                        HI_Wr   = 1'b1;
                        HI_Data = EXE_BusA;
                    end else if (!EXE_Flush && op_mtlo) begin
                        LO_Wr   = 1'b1;
                        LO_Data = EXE_BusA;
                    end
                end
                S_MUL_WAIT: begin
                    MDU_Busy = !EXE_Flush;
                end
                S_DIV_WAIT: begin
                    // A Div_Done coinciding with the flush is dropped along with the op.
                    MDU_Busy  = !EXE_Flush;
                    Div_Abort = EXE_Flush;
                end
                S_DONE: begin
                    HI_Wr = !written && !EXE_Flush;
                    LO_Wr = !written && !EXE_Flush;
                end
                S_DRAIN: begin
                    // Hold a new request for one cycle; it launches from IDLE next cycle.
                    MDU_Busy = launch_req;
                end
                default: begin
                    MDU_Busy = 1'b0;
                end
            endcase
        end
    end

endmodule
